// File: rtl/display_digit_scanner.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a time-multiplexed
// single-digit display scan with optional leading-zero blanking.
module display_digit_scanner #(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter bit          BLANK_LZ   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     value_in,
    input  logic                  value_valid,
    output logic [3:0]            digit_num,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  busy,
    output logic                  overflow
);

    localparam int unsigned BCD_W   = 4 * NUM_DIGITS;
    localparam int unsigned MAX_VAL = 10 ** NUM_DIGITS - 1;
    localparam int unsigned CNT_W   = $clog2(DATA_W + 1);
    localparam int unsigned PRE_W   = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {StIdle, StConvert, StLatch} state_e;

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     bin_q, bin_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovf_next_q, ovf_next_d;
    logic                  pend_q, pend_d;
    logic [DATA_W-1:0]     pend_val_q, pend_val_d;
    logic [BCD_W-1:0]      disp_q, disp_d;
    logic                  overflow_q, overflow_d;
    logic                  busy_q, busy_d;
    logic [PRE_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [3:0]            num_q, num_d;
    logic [NUM_DIGITS-1:0] sel_pre_q, sel_pre_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;

    logic [DATA_W-1:0]     src;
    logic [BCD_W-1:0]      adj;
    logic [NUM_DIGITS-1:0] blank;
    logic                  zero_above;

    // Conversion FSM and pending-value capture
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_next_d = ovf_next_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        disp_d     = disp_q;
        overflow_d = overflow_q;
        adj        = bcd_q;
        src        = value_valid ? value_in : pend_val_q;

        case (state_q)
            StIdle: begin
                if (value_valid || pend_q) begin
                    pend_d = 1'b0;
                    if (32'(src) > MAX_VAL) begin
                        bcd_d      = {NUM_DIGITS{4'd9}};
                        ovf_next_d = 1'b1;
                        state_d    = StLatch;
                    end else begin
                        bin_d      = src;
                        bcd_d      = '0;
                        cnt_d      = CNT_W'(DATA_W);
                        ovf_next_d = 1'b0;
                        state_d    = StConvert;
                    end
                end
            end
            StConvert: begin
                for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                    if (bcd_q[i*4 +: 4] >= 4'd5) begin
                        adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
                    end
                end
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StLatch;
                end
            end
            StLatch: begin
                disp_d     = bcd_q;
                overflow_d = ovf_next_q;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Strobes arriving while a conversion owns the engine wait here; newest wins.
        if (value_valid && (state_q != StIdle)) begin
            pend_d     = 1'b1;
            pend_val_d = value_in;
        end

        busy_d = (state_d != StIdle) || (state_q == StLatch);
    end

    // Scan prescaler, digit fetch and blanking
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        num_d      = disp_q[{idx_q, 2'b00} +: 4];
        blank      = '0;
        zero_above = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_above = zero_above && (disp_q[i*4 +: 4] == 4'd0);
            blank[i]   = zero_above && (i != 0) && BLANK_LZ;
        end
        sel_pre_d = blank[idx_q] ? '0 : (NUM_DIGITS'(1) << idx_q);
        // Extra stage so the enable moves with the decoder's registered output.
        sel_d     = sel_pre_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_next_q <= 1'b0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            disp_q     <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            presc_q    <= '0;
            idx_q      <= '0;
            num_q      <= '0;
            sel_pre_q  <= '0;
            sel_q      <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_next_q <= ovf_next_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            disp_q     <= disp_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            num_q      <= num_d;
            sel_pre_q  <= sel_pre_d;
            sel_q      <= sel_d;
        end
    end

    assign digit_num = num_q;
    assign digit_sel = sel_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_display_digit_scanner.sv
// Randomized bench for display_digit_scanner against a decimal-arithmetic model,
// plus a 3-digit instance exercising the overflow path.
module tb_display_digit_scanner;

    localparam int DW   = 12;
    localparam int ND   = 4;
    localparam int DIV  = 4;
    localparam int ND3  = 3;

    logic          clk;
    logic          rst;
    logic [DW-1:0] vin, vin3;
    logic          vv, vv3;
    logic [3:0]    num, num3;
    logic [ND-1:0] sel;
    logic [ND3-1:0] sel3;
    logic          busy, busy3, ovf, ovf3;

    int n_chk = 0;
    int n_err = 0;

    display_digit_scanner #(.DATA_W(DW), .NUM_DIGITS(ND), .SCAN_DIV(DIV), .BLANK_LZ(1'b1)) u_dut (
        .clk(clk), .rst(rst), .value_in(vin), .value_valid(vv),
        .digit_num(num), .digit_sel(sel), .busy(busy), .overflow(ovf)
    );

    display_digit_scanner #(.DATA_W(DW), .NUM_DIGITS(ND3), .SCAN_DIV(DIV), .BLANK_LZ(1'b1)) u_dut3 (
        .clk(clk), .rst(rst), .value_in(vin3), .value_valid(vv3),
        .digit_num(num3), .digit_sel(sel3), .busy(busy3), .overflow(ovf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state for u_dut: whole-number display value, job timing, scan position
    int m_disp, m_ovf, job_on, job_left, job_res, job_ovf;
    int pend_on, pend_v, tail, m_presc, m_idx, e_num, e_sel, sel_pre;

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_start(input int v);
        job_on = 1;
        if (v > pow10(ND) - 1) begin
            job_res = pow10(ND) - 1; job_ovf = 1; job_left = 1;
        end else begin
            job_res = v; job_ovf = 0; job_left = DW + 1;
        end
    endtask

    task automatic model_step();
        int upd;
        if (rst) begin
            m_disp = 0; m_ovf = 0; job_on = 0; job_left = 0; job_res = 0; job_ovf = 0;
            pend_on = 0; pend_v = 0; tail = 0; m_presc = 0; m_idx = 0;
            e_num = 0; e_sel = 0; sel_pre = 0;
        end else begin
            e_num   = (m_disp / pow10(m_idx)) % 10;
            e_sel   = sel_pre;
            sel_pre = (m_idx != 0 && m_disp < pow10(m_idx)) ? 0 : (1 << m_idx);
            if (m_presc == DIV - 1) begin
                m_presc = 0;
                m_idx   = (m_idx + 1) % ND;
            end else begin
                m_presc++;
            end
            upd = 0;
            if (job_on != 0) begin
                job_left--;
                if (job_left == 0) begin
                    m_disp = job_res; m_ovf = job_ovf; job_on = 0; upd = 1;
                end
                if (vv) begin
                    pend_on = 1; pend_v = int'(vin);
                end
            end else if (vv || pend_on != 0) begin
                model_start(vv ? int'(vin) : pend_v);
                pend_on = 0;
            end
            tail = upd;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("busy", int'(busy), (job_on != 0 || tail != 0) ? 1 : 0);
        check("overflow", int'(ovf), m_ovf);
        check("digit_num", int'(num), e_num);
        check("digit_sel", int'(sel), e_sel);
    endtask

    task automatic strobe(input int v);
        vin = DW'(v);
        vv  = 1'b1;
        cycle();
        vv  = 1'b0;
    endtask

    task automatic strobe3(input int v);
        vin3 = DW'(v);
        vv3  = 1'b1;
        cycle();
        vv3  = 1'b0;
    endtask

    // Each enabled slot of u_dut3 must show 9, and all three digits must appear.
    task automatic scan3_nines();
        int seen = 0;
        int prev = int'(num3);
        repeat (4 * DIV + 2) begin
            cycle();
            if (sel3 != 0) begin
                check("dig3_nine", prev, 9);
                check("sel3_onehot", int'($onehot(sel3)), 1);
            end
            seen = seen | int'(sel3);
            prev = int'(num3);
        end
        check("sel3_cover", seen, 7);
    endtask

    initial begin
        int blen;
        rst = 1'b1; vv = 1'b0; vin = '0; vv3 = 1'b0; vin3 = '0;
        repeat (3) cycle();
        rst = 1'b0;
        cycle();
        check("rst3_busy", int'(busy3), 0);
        check("rst3_ovf", int'(ovf3), 0);

        // 1234: busy length and digit scan
        strobe(1234);
        blen = int'(busy);
        repeat (30) begin
            cycle();
            blen += int'(busy);
        end
        check("busy_len_1234", blen, 14);
        repeat (20) cycle();

        // Blanking of small values and zero
        strobe(7);
        repeat (40) cycle();
        strobe(0);
        repeat (40) cycle();

        // Back-to-back: 200 is overwritten by 300 in the pending slot
        strobe(100);
        repeat (3) cycle();
        strobe(200);
        repeat (3) cycle();
        strobe(300);
        repeat (60) cycle();

        // Reset in the middle of a conversion
        strobe(555);
        repeat (5) cycle();
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        repeat (30) cycle();

        // Overflow on the 3-digit instance
        strobe3(1000);
        repeat (4) cycle();
        check("ovf3_set", int'(ovf3), 1);
        scan3_nines();
        strobe3(999);
        repeat (16) cycle();
        check("ovf3_clr", int'(ovf3), 0);
        check("busy3_idle", int'(busy3), 0);
        scan3_nines();

        // Randomized strobes, gaps and occasional resets
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) cycle();
                rst = 1'b0;
            end
            strobe(int'($urandom_range(0, (1 << DW) - 1)));
            repeat ($urandom_range(0, 25)) cycle();
        end
        repeat (40) cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
